// File: rtl/cache_arbiter_pkg.sv
// Shared types for the I/D cache-to-physical-memory arbiter.
// Holds the arbiter FSM state encoding and the requester identifiers.
package cache_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } arb_state_e;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } req_id_e;

endpackage

// File: rtl/cache_arbiter.sv
// Arbitrates icache and dcache line requests onto one physical-memory port.
// Round-robin on contention, one transaction in flight, combinational pmem drive.
module cache_arbiter
    import cache_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              i_read,
    input  logic              i_write,
    input  logic [ADDR_W-1:0] i_address,
    input  logic [LINE_W-1:0] i_wdata,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,

    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,

    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    arb_state_e state_q, state_d;
    req_id_e    last_grant_q, last_grant_d;
    req_id_e    grant;

    logic i_pend;
    logic d_pend;

    assign i_pend = i_read | i_write;
    assign d_pend = d_read | d_write;

    // Returned lines fan out to both caches; each only trusts it alongside its resp.
    assign i_rdata = pmem_rdata;
    assign d_rdata = pmem_rdata;

    // Under contention the side not granted last time wins.
    function automatic req_id_e rr_pick(input logic    i_p,
                                        input logic    d_p,
                                        input req_id_e last);
        if (i_p && d_p) begin
            return (last == REQ_I) ? REQ_D : REQ_I;
        end else if (d_p) begin
            return REQ_D;
        end
        return REQ_I;
    endfunction

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        i_resp       = 1'b0;
        d_resp       = 1'b0;
        grant        = rr_pick(i_pend, d_pend, last_grant_q);

        case (state_q)
            IDLE: begin
                if (i_pend || d_pend) begin
                    last_grant_d = grant;
                    state_d      = (grant == REQ_D) ? SERVE_D : SERVE_I;
                end
            end

            SERVE_I: begin
                pmem_write   = i_write;
                pmem_read    = i_read & ~i_write;
                pmem_address = i_address;
                pmem_wdata   = i_wdata;
                // A requester that lets go early is abandoned without a resp.
                if (!i_pend) begin
                    state_d = IDLE;
                end else if (pmem_resp) begin
                    i_resp  = 1'b1;
                    state_d = IDLE;
                end
            end

            SERVE_D: begin
                pmem_write   = d_write;
                pmem_read    = d_read & ~d_write;
                pmem_address = d_address;
                pmem_wdata   = d_wdata;
                if (!d_pend) begin
                    state_d = IDLE;
                end else if (pmem_resp) begin
                    d_resp  = 1'b1;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // last_grant resets to icache so the dcache wins the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= REQ_I;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, memory byte-address width.
REQ-002 SHALL have parameter LINE_W, default 256, cache-line width in bits.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports i_read, i_write  input  1 each  icache line read/write request.
REQ-006 SHALL have ports i_address  input  ADDR_W; i_wdata  input  LINE_W; icache request address/data.
REQ-007 SHALL have ports i_rdata  output  LINE_W; i_resp  output  1; icache returned line and one-cycle completion pulse.
REQ-008 SHALL have ports d_read, d_write, d_address, d_wdata, d_rdata, d_resp with the same directions, widths and meanings for the dcache.
REQ-009 SHALL have ports pmem_read, pmem_write  output  1; pmem_address  output  ADDR_W; pmem_wdata  output  LINE_W; shared physical-memory request.
REQ-010 SHALL have ports pmem_rdata  input  LINE_W; pmem_resp  input  1; physical-memory returned line and completion pulse.

Function
REQ-011 SHALL implement FSM states IDLE, SERVE_I, SERVE_D, held in one state register.
REQ-012 SHALL, in IDLE, assert no pmem_read/pmem_write and no i_resp/d_resp.
REQ-013 SHALL treat a requester as pending when its read or write is high; write wins if both are high.
REQ-014 SHALL, from IDLE with only icache pending, move to SERVE_I next edge; only dcache pending, to SERVE_D.
REQ-015 SHALL, from IDLE with both pending, grant the requester not granted last (round-robin); after reset, dcache wins first.
REQ-016 SHALL update a last_grant register on every IDLE-to-SERVE transition.
REQ-017 SHALL, in SERVE_x, drive pmem_read/pmem_write/pmem_address/pmem_wdata combinationally from requester x.
REQ-018 SHALL, in SERVE_x with pmem_resp high, assert x_resp in that same cycle and return to IDLE next edge.
REQ-019 SHALL never assert i_resp and d_resp in the same cycle, nor x_resp outside SERVE_x.
REQ-020 SHALL drive i_rdata and d_rdata from pmem_rdata at all times (valid only with resp).
REQ-021 SHALL give latency of exactly one cycle from a request seen in IDLE to the pmem request; the minimum transaction is 2 cycles (request to resp).
REQ-022 SHALL ignore pmem_resp received in IDLE.
REQ-023 SHALL require requesters to hold request/address/data stable until their resp; behaviour if they drop early is a forced return to IDLE next edge with no resp.
REQ-024 SHALL, for a requester whose request is still high after its resp, treat it as a fresh request arbitrated in IDLE, so back-to-back transactions interleave under contention.

Reset
REQ-025 SHALL, while rst_n is low, force state IDLE and last_grant to icache (so dcache wins first), independent of clk.
REQ-026 SHALL drop pmem_read, pmem_write, i_resp, d_resp to 0 immediately on rst_n falling, including mid-transaction; an in-flight transaction is abandoned.

Structure
REQ-027 SHALL place the FSM state enum and the requester-id enum (REQ_I, REQ_D) in the shared rv32i_types-style package.
REQ-028 SHALL be a single module with no sub-modules; the round-robin grant decision is a local function.

Verification
REQ-029 SHALL test lone icache read 0x0000_0060: pmem_read high the cycle after request, address 0x60; pmem_resp with line 0xAA..AA in cycle 4 -> i_resp=1, i_rdata=0xAA..AA that cycle, d_resp=0.
REQ-030 SHALL test simultaneous i_read 0x100 and d_write 0x200 after reset -> dcache served first (pmem_write, address 0x200), then icache (address 0x100).
REQ-031 SHALL test both requesters held high across four transactions -> grants alternate D,I,D,I; no requester is served twice in succession.
REQ-032 SHALL test rst_n low while in SERVE_D with pmem_write high -> pmem_write and d_resp 0 same cycle; after release, state IDLE, next contention granted to dcache.
REQ-033 SHALL test spurious pmem_resp in IDLE -> no i_resp/d_resp, state unchanged.
REQ-034 SHALL test d_read and d_write both high at 0x300 -> pmem_write asserted, pmem_read low.
